ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit for the single-issue MIPS datapath.
- Holds the PC, runs the request/acknowledge handshake with instruction memory, and latches the returned word into an instruction register.
- Splits the instruction into fields. imm16 drives the immediate extender; opcode/funct drive control.
- Computes the next PC from the extender's 32-bit result (branches), the jump index, or a register target.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high only in state FETCH.
- imem_addr  out  32  fetch address; equals pc, stable while imem_req is high.
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored unless imem_req is high.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- stall  in  1  hold: blocks retire.
- retire  in  1  consumer finished the current instruction.
- npc_op  in  2  next-PC select: 00 PC+4; 01 branch; 10 jump; 11 jr.
- br_taken  in  1  branch condition; used only when npc_op=01.
- imm32  in  32  extended immediate from the extender stage.
- jr_target  in  32  register value for jr.
- instr_valid  out  1  instr and the field outputs are valid.
- instr  out  32  instruction register.
- pc  out  32  address of the instruction held in instr.
- opcode  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- funct  out  6  instr[5:0].
- imm16  out  16  instr[15:0].
- instr_cnt  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (asynchronous, takes effect immediately when rst_n low):
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, instr_cnt=0, imem_req=0.
  - Reset asserted mid-fetch or mid-execute aborts the operation; a pending ack is discarded.
- FSM states: IDLE, FETCH, EXEC.
  - IDLE -> FETCH on the first clock edge after rst_n releases.
  - FETCH: imem_req=1, imem_addr=pc. On a clock edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, state->EXEC. Without ack, remain in FETCH with address held; there is no timeout.
  - EXEC: imem_req=0. On a clock edge with retire=1 and stall=0: pc<=npc, instr_cnt<=instr_cnt+1 (wraps modulo 2^CNT_W), instr_valid<=0, state->FETCH. Otherwise hold all state.
- retire outside EXEC is ignored. retire together with stall=1 is ignored.
- Next-PC arithmetic (all 32-bit, modulo 2^32; pc4 = pc+4):
  - 00 -> pc4.
  - 01 -> br_taken ? pc4 + (imm32<<2) : pc4.
  - 10 -> {pc4[31:28], instr[25:0], 2'b00}.
  - 11 -> {jr_target[31:2], 2'b00}; the low two bits are forced to zero.
- Field outputs are continuous slices of instr; their values are held when instr_valid=0.
- Latency:
  - Minimum of 2 cycles per instruction: FETCH with same-cycle ack, then EXEC with immediate retire.
  - imem_req rises the cycle after retire.

Test Plan:
- Reset release with ack tied high:
  - imem_req=1 with imem_addr=0x3000 on the second cycle.
  - instr_valid=1 next cycle.
  - retire with npc_op=00 -> pc=0x3004, instr_cnt=1.
- Ack delayed 5 cycles:
  - imem_req and imem_addr=0x3000 stay stable throughout.
  - An ack pulse while in EXEC is ignored.
- Branch:
  - pc=0x3010, npc_op=01, br_taken=1, imm32=0xFFFFFFFE -> next pc=0x300C.
  - Same stimulus with br_taken=0 -> next pc=0x3014.
- Jump and jr:
  - instr=0x0800_0C00 at pc=0x3000, npc_op=10 -> next pc=0x3000.
  - npc_op=11, jr_target=0x0000_4007 -> next pc=0x4004.
- Stall:
  - retire=1 with stall=1 for 3 cycles -> pc, instr and instr_cnt unchanged.
  - Dropping stall -> retire occurs on that edge.
- Wrap and reset:
  - pc=0xFFFF_FFFC, npc_op=00 -> next pc=0x0000_0000.
  - Drop rst_n mid-FETCH -> imem_req falls immediately, pc=0x3000, instr_valid=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, imem handshake, instruction register, next-PC select
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             retire,
  input  logic [1:0]       npc_op,
  input  logic             br_taken,
  input  logic [31:0]      imm32,
  input  logic [31:0]      jr_target,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        do_load, do_retire;
  logic [31:0] pc4, npc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    do_load   = 1'b0;
    do_retire = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          do_load   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (retire && !stall) begin
          do_retire = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Branch offset is a word offset; jump keeps the upper nibble of pc+4.
  always_comb begin
    pc4 = pc + 32'd4;
    npc = pc4;
    case (npc_op)
      2'b00: npc = pc4;
      2'b01: npc = br_taken ? (pc4 + {imm32[29:0], 2'b00}) : pc4;
      2'b10: npc = {pc4[31:28], instr[25:0], 2'b00};
      2'b11: npc = {jr_target[31:2], 2'b00};
      default: npc = pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      instr_cnt   <= '0;
    end else if (do_load) begin
      instr       <= imem_rdata;
      instr_valid <= 1'b1;
    end else if (do_retire) begin
      pc          <= npc;
      instr_cnt   <= instr_cnt + 1'b1;
      instr_valid <= 1'b0;
    end
  end

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign imm16     = instr[15:0];

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b1;
  logic [31:0] imem_rdata = 32'h2001_0005;
  logic        stall = 1'b0;
  logic        retire = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic        br_taken = 1'b0;
  logic [31:0] imm32 = 32'd0;
  logic [31:0] jr_target = 32'd0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] instr_cnt;

  int tests = 0;
  int fails = 0;

  ifu_fetch #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .retire(retire), .npc_op(npc_op), .br_taken(br_taken),
    .imm32(imm32), .jr_target(jr_target),
    .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 = just out of reset, 1 = waiting for memory, 2 = holding an instruction.
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_cnt;
  logic        m_valid;

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ir,
                                            input logic [1:0] op, input logic tk,
                                            input logic [31:0] imm, input logic [31:0] jr);
    logic [31:0] seq;
    seq = p + 32'd4;
    case (op)
      2'b00:   return seq;
      2'b01:   return tk ? seq + imm * 32'd4 : seq;
      2'b10:   return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
      default: return jr & ~32'd3;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_pc = 32'h0000_3000; m_instr = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (imem_ack) begin
        m_instr = imem_rdata; m_valid = 1'b1; m_phase = 2;
      end
    end else if (retire && !stall) begin
      m_pc = model_npc(m_pc, m_instr, npc_op, br_taken, imm32, jr_target);
      m_cnt = m_cnt + 32'd1; m_valid = 1'b0; m_phase = 1;
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("req", {31'd0, imem_req}, {31'd0, m_phase == 1});
      if (m_phase == 1) chk("addr", imem_addr, m_pc);
      chk("valid", {31'd0, instr_valid}, {31'd0, m_valid});
      chk("pc", pc, m_pc);
      chk("instr", instr, m_instr);
      chk("cnt", instr_cnt, m_cnt);
      chk("fields", {opcode, rs, rt, rd, shamt, funct}, m_instr);
      chk("imm16", {16'd0, imm16}, {16'd0, m_instr[15:0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [31:0] word);
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic retire_one(input logic [1:0] op, input logic tk,
                            input logic [31:0] imm, input logic [31:0] jr);
    npc_op = op; br_taken = tk; imm32 = imm; jr_target = jr; retire = 1'b1;
    step();
    retire = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    rst_n = 1'b1;
    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);
    step();
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_instr", instr, 32'h2001_0005);
    imem_ack = 1'b0;
    retire_one(2'b00, 1'b0, 32'd0, 32'd0);
    chk("seq_pc", pc, 32'h0000_3004);
    chk("seq_cnt", instr_cnt, 32'd1);
    chk("seq_req", {31'd0, imem_req}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h0000_3004);
    end
    fetch_one(32'h0123_4567);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    imem_ack = 1'b0;
    chk("exec_ack_ignored", instr, 32'h0123_4567);
    chk("exec_no_req", {31'd0, imem_req}, 32'd0);

    retire_one(2'b00, 1'b0, 32'd0, 32'd0);
    fetch_one(32'h0000_0020);
    retire_one(2'b00, 1'b0, 32'd0, 32'd0);
    fetch_one(32'h0000_0021);
    retire_one(2'b00, 1'b0, 32'd0, 32'd0);
    chk("pre_br_pc", pc, 32'h0000_3010);
    fetch_one(32'h1000_FFFE);
    retire_one(2'b01, 1'b1, 32'hFFFF_FFFE, 32'd0);
    chk("br_taken_pc", pc, 32'h0000_300C);
    fetch_one(32'h0000_0022);
    retire_one(2'b00, 1'b0, 32'd0, 32'd0);
    fetch_one(32'h1000_FFFE);
    retire_one(2'b01, 1'b0, 32'hFFFF_FFFE, 32'd0);
    chk("br_nt_pc", pc, 32'h0000_3014);

    fetch_one(32'h0000_0008);
    retire_one(2'b11, 1'b0, 32'd0, 32'h0000_3002);
    chk("jr_to_3000", pc, 32'h0000_3000);
    fetch_one(32'h0800_0C00);
    retire_one(2'b10, 1'b0, 32'd0, 32'd0);
    chk("jump_pc", pc, 32'h0000_3000);
    fetch_one(32'h0000_0008);
    retire_one(2'b11, 1'b0, 32'd0, 32'h0000_4007);
    chk("jr_pc", pc, 32'h0000_4004);
    chk("jr_cnt", instr_cnt, 32'd10);

    fetch_one(32'h0042_0820);
    npc_op = 2'b00; retire = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h0000_4004);
      chk("stall_instr", instr, 32'h0042_0820);
      chk("stall_cnt", instr_cnt, 32'd10);
    end
    stall = 1'b0;
    step();
    retire = 1'b0;
    chk("unstall_pc", pc, 32'h0000_4008);
    chk("unstall_cnt", instr_cnt, 32'd11);

    fetch_one(32'h0000_0008);
    retire_one(2'b11, 1'b0, 32'd0, 32'hFFFF_FFFC);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    fetch_one(32'h0000_0000);
    retire_one(2'b00, 1'b0, 32'd0, 32'd0);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_cnt", instr_cnt, 32'd13);

    step();
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0000_3000);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_cnt", instr_cnt, 32'd0);
    step();
    step();
    chk("arst_hold_instr", instr, 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rerun_req", {31'd0, imem_req}, 32'd1);
    chk("rerun_addr", imem_addr, 32'h0000_3000);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
